// File: rtl/bridge_pkg.sv
// Shared types and constants for the SRAM-to-AXI3 bridge: FSM states, port IDs,
// access-size encodings and the fixed AXI attribute values.
package bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AW_W,
    S_B,
    S_DONE
  } state_e;

  // Port select doubles as the AXI ID: instruction side 0, data side 1.
  localparam logic PORT_INST = 1'b0;
  localparam logic PORT_DATA = 1'b1;
  localparam int   ID_INST   = 0;
  localparam int   ID_DATA   = 1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_LOCK_NORM  = 2'b00;
  localparam logic [3:0] AXI_CACHE_NONE = 4'b0000;
  localparam logic [2:0] AXI_PROT_NONE  = 3'b000;
  localparam int         AXI_WID_TIE    = 1;

endpackage

// File: rtl/wstrb_gen.sv
// Byte-lane write strobe from access size and the low address bits.
module wstrb_gen
  import bridge_pkg::*;
(
  input  logic [1:0] size_i,
  input  logic [1:0] offset_i,
  output logic [3:0] strb_o
);

  always_comb begin
    case (size_i)
      SIZE_BYTE: strb_o = 4'b0001 << offset_i;
      SIZE_HALF: strb_o = 4'b0011 << offset_i;
      default:   strb_o = 4'b1111;
    endcase
  end

endmodule

// File: rtl/sram_axi_bridge.sv
// Arbitrates the core's instruction and data SRAM-like ports onto one AXI3 master,
// one transaction in flight; the data port wins same-cycle ties.
module sram_axi_bridge
  import bridge_pkg::*;
#(
  parameter int AXI_ID_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic                inst_wr,
  input  logic [1:0]          inst_size,
  input  logic [31:0]         inst_addr,
  input  logic [31:0]         inst_wdata,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [31:0]         inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [31:0]         data_addr,
  input  logic [31:0]         data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [31:0]         data_rdata,
  output logic [AXI_ID_W-1:0] arid,
  output logic [31:0]         araddr,
  output logic [3:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic [1:0]          arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  input  logic [AXI_ID_W-1:0] rid,
  input  logic [31:0]         rdata,
  input  logic                rvalid,
  output logic                rready,
  output logic [AXI_ID_W-1:0] awid,
  output logic [31:0]         awaddr,
  output logic [3:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [1:0]          awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  output logic [AXI_ID_W-1:0] wid,
  output logic [31:0]         wdata,
  output logic [3:0]          wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic                bvalid,
  output logic                bready
);

  state_e      state_q, state_d;
  logic        port_q, port_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic [3:0]  strb;
  logic        unused_in;

  // rid needs no check with a single outstanding transaction; inst side never writes.
  assign unused_in = ^{rid, inst_wr, inst_wdata};

  wstrb_gen u_wstrb_gen (
    .size_i   (size_q),
    .offset_i (addr_q[1:0]),
    .strb_o   (strb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      port_q       <= PORT_INST;
      wr_q         <= 1'b0;
      size_q       <= 2'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      inst_rdata_q <= 32'd0;
      data_rdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      port_q       <= port_d;
      wr_q         <= wr_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    wr_d         = wr_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (data_req) begin
          data_addr_ok = 1'b1;
          port_d       = PORT_DATA;
          wr_d         = data_wr;
          size_d       = data_size;
          addr_d       = data_addr;
          wdata_d      = data_wdata;
          state_d      = data_wr ? S_AW_W : S_AR;
        end else if (inst_req) begin
          inst_addr_ok = 1'b1;
          port_d       = PORT_INST;
          wr_d         = 1'b0;
          size_d       = inst_size;
          addr_d       = inst_addr;
          state_d      = S_AR;
        end
      end
      S_AR: begin
        arvalid = 1'b1;
        if (arready) state_d = S_R;
      end
      S_R: begin
        rready = 1'b1;
        if (rvalid) begin
          if (port_q == PORT_DATA) data_rdata_d = rdata;
          else                     inst_rdata_d = rdata;
          state_d = S_DONE;
        end
      end
      S_AW_W: begin
        // Address and data channels complete independently; leave once both have.
        awvalid   = !aw_done_q;
        wvalid    = !w_done_q;
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_B;
        end
      end
      S_B: begin
        bready = 1'b1;
        if (bvalid) state_d = S_DONE;
      end
      S_DONE: begin
        inst_data_ok = (port_q == PORT_INST);
        data_data_ok = (port_q == PORT_DATA);
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;

  assign arid    = (port_q == PORT_DATA) ? AXI_ID_W'(ID_DATA) : AXI_ID_W'(ID_INST);
  assign araddr  = addr_q;
  assign arsize  = {1'b0, size_q};
  assign arlen   = AXI_LEN_SINGLE;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = AXI_LOCK_NORM;
  assign arcache = AXI_CACHE_NONE;
  assign arprot  = AXI_PROT_NONE;

  assign awid    = arid;
  assign awaddr  = addr_q;
  assign awsize  = {1'b0, size_q};
  assign awlen   = AXI_LEN_SINGLE;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = AXI_LOCK_NORM;
  assign awcache = AXI_CACHE_NONE;
  assign awprot  = AXI_PROT_NONE;

  assign wid   = AXI_ID_W'(AXI_WID_TIE);
  assign wdata = wdata_q;
  assign wstrb = wvalid ? strb : 4'b0000;
  assign wlast = 1'b1;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: a configurable-latency AXI slave, a queue of
// expected responses, and a monitor that checks every *_data_ok pulse against it.
module tb_sram_axi_bridge;
  localparam int IDW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            inst_req = 0, inst_wr = 0, data_req = 0, data_wr = 0;
  logic [1:0]      inst_size = 0, data_size = 0;
  logic [31:0]     inst_addr = 0, inst_wdata = 0, data_addr = 0, data_wdata = 0;
  logic            inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0]     inst_rdata, data_rdata;
  logic [IDW-1:0]  arid, awid, wid;
  logic [31:0]     araddr, awaddr, wdata;
  logic [3:0]      arlen, arcache, awlen, awcache, wstrb;
  logic [2:0]      arsize, arprot, awsize, awprot;
  logic [1:0]      arburst, arlock, awburst, awlock;
  logic            arvalid, rready, awvalid, wlast, wvalid, bready;
  logic            arready = 0, rvalid = 0, awready = 0, wready = 0, bvalid = 0;
  logic [IDW-1:0]  rid = 0;
  logic [31:0]     rdata = 0;

  sram_axi_bridge #(.AXI_ID_W(IDW)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave: each ready/valid rises once its channel has waited the configured delay.
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  int aw_hi = 0, w_hi = 0;
  logic [31:0] ar_lat = 0;

  function automatic logic [31:0] slave_word(input logic [31:0] a);
    case (a)
      32'h1000_0004: return 32'hDEAD_BEEF;
      32'h1000_0008: return 32'hCAFE_F00D;
      32'h0000_0100: return 32'h1111_1111;
      32'h0000_0104: return 32'h2222_2222;
      32'h0000_0108: return 32'h3333_3333;
      32'h0000_010C: return 32'h4444_4444;
      default:       return 32'hBAD0_0000;
    endcase
  endfunction

  always @(negedge clk) begin
    arready <= arvalid && (ar_cnt >= ar_dly);
    if (arvalid && (ar_cnt >= ar_dly)) ar_lat <= araddr;
    ar_cnt  <= arvalid ? ar_cnt + 1 : 0;
    rvalid  <= rready && (r_cnt >= r_dly);
    rdata   <= (rready && (r_cnt >= r_dly)) ? slave_word(ar_lat) : 32'h0;
    r_cnt   <= rready ? r_cnt + 1 : 0;
    awready <= awvalid && (aw_cnt >= aw_dly);
    aw_cnt  <= awvalid ? aw_cnt + 1 : 0;
    wready  <= wvalid && (w_cnt >= w_dly);
    w_cnt   <= wvalid ? w_cnt + 1 : 0;
    bvalid  <= bready && (b_cnt >= b_dly);
    b_cnt   <= bready ? b_cnt + 1 : 0;
    if (awvalid) aw_hi <= aw_hi + 1;
    if (wvalid)  w_hi  <= w_hi + 1;
  end

  typedef struct {
    bit          is_data;
    bit          wr;
    logic [31:0] data;
  } exp_t;

  exp_t expq[$];
  int n_tests = 0, n_fail = 0, last_ok_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input bit is_data, input bit wr, input logic [31:0] d);
    exp_t e;
    e.is_data = is_data;
    e.wr      = wr;
    e.data    = d;
    expq.push_back(e);
  endtask

  task automatic issue(input bit is_data, input bit wr, input logic [1:0] sz,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, output int acc);
    bit got;
    got = 0;
    acc = -1;
    push_exp(is_data, wr, exp_rd);
    if (is_data) begin
      data_req = 1; data_wr = wr; data_size = sz; data_addr = addr; data_wdata = wd;
    end else begin
      inst_req = 1; inst_wr = wr; inst_size = sz; inst_addr = addr; inst_wdata = wd;
    end
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (is_data ? data_addr_ok : inst_addr_ok) begin
        got = 1;
        acc = cyc;
      end
    end
    @(posedge clk); #1;
    if (is_data) data_req = 0;
    else         inst_req = 0;
    check("addr_ok_seen", got, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain", expq.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, acc3, c0, c1, aw0, w0;
    bit got;

    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && (inst_data_ok || data_data_ok)) begin
          if (inst_data_ok && data_data_ok)
            check("dual_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
          else if (expq.size() == 0)
            check("unexpected_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
          else begin
            e = expq.pop_front();
            last_ok_cyc = cyc;
            check("data_ok_port", data_data_ok, e.is_data);
            if (!e.wr) check("rdata", e.is_data ? data_rdata : inst_rdata, e.data);
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {arvalid, rready, awvalid, wvalid, bready,
                       inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
    check("rst_addr", {araddr, awaddr}, 0);
    check("rst_wdata", {wdata, wstrb}, 0);
    check("rst_rdata", {inst_rdata, data_rdata}, 0);
    @(posedge clk); #1;
    rst = 0;
    repeat (2) @(posedge clk); #1;

    // Data word read, zero-wait slave
    issue(1, 0, 2'd2, 32'h1000_0004, 0, 32'hDEAD_BEEF, acc);
    @(negedge clk);
    check("rd_arvalid", arvalid, 1);
    check("rd_arsize", arsize, 3'b010);
    check("rd_arid", arid, 1);
    check("rd_araddr", araddr, 32'h1000_0004);
    check("rd_fixed", {arlen, arburst, arlock, arcache, arprot}, 15'b0000_01_00_0000_000);
    wait_idle();
    check("rd_latency", last_ok_cyc - acc, 3);

    // Byte write at offset 3, awready 3 cycles late
    aw_dly = 3;
    aw0 = aw_hi;
    w0 = w_hi;
    issue(1, 1, 2'd0, 32'h2000_0003, 32'h0000_00AB, 0, acc);
    @(negedge clk);
    check("bw_wstrb", wstrb, 4'b1000);
    check("bw_wdata", wdata, 32'h0000_00AB);
    check("bw_awsize", awsize, 3'b000);
    check("bw_awaddr", awaddr, 32'h2000_0003);
    check("bw_wfixed", {wlast, wid}, {1'b1, 4'd1});
    wait_idle();
    check("bw_awvalid_cycles", aw_hi - aw0, 4);
    check("bw_wvalid_cycles", w_hi - w0, 1);
    check("bw_latency", last_ok_cyc - acc, 6);
    aw_dly = 0;

    // Preload inst_rdata, then simultaneous requests (inst_wr set but ignored)
    issue(0, 0, 2'd2, 32'h0000_010C, 0, 32'h4444_4444, acc);
    wait_idle();
    push_exp(1, 0, 32'hCAFE_F00D);
    push_exp(0, 0, 32'h1111_1111);
    data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h1000_0008;
    inst_req = 1; inst_wr = 1; inst_size = 2'd2; inst_addr = 32'h0000_0100;
    @(negedge clk);
    c0 = cyc;
    check("tie_data_addr_ok", data_addr_ok, 1);
    check("tie_inst_blocked", inst_addr_ok, 0);
    @(posedge clk); #1;
    data_req = 0;
    got = 0;
    c1 = -1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (cyc == c0 + 3) check("tie_inst_rdata_hold", inst_rdata, 32'h4444_4444);
      if (inst_addr_ok) begin
        got = 1;
        c1 = cyc;
      end
    end
    check("tie_inst_spacing", c1 - c0, 4);
    @(posedge clk); #1;
    inst_req = 0;
    inst_wr = 0;
    wait_idle();

    // Half write at offset 2
    issue(1, 1, 2'd1, 32'h3000_0002, 32'h5A5A_0000, 0, acc);
    @(negedge clk);
    check("hw_wstrb", wstrb, 4'b1100);
    check("hw_awsize", awsize, 3'b001);
    check("hw_awid", awid, 1);
    wait_idle();

    // Reset while waiting in R with rvalid held off
    r_dly = 50;
    issue(0, 0, 2'd2, 32'h0000_0104, 0, 32'h2222_2222, acc);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_in_R", rready, 1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("mid_rst_ctrl", {arvalid, rready, awvalid, wvalid, bready,
                           inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
    check("mid_rst_addr", {araddr, awaddr}, 0);
    check("mid_rst_rdata", {inst_rdata, data_rdata}, 0);
    void'(expq.pop_back());
    r_dly = 0;
    repeat (3) @(posedge clk); #1;
    issue(0, 0, 2'd2, 32'h0000_0108, 0, 32'h3333_3333, acc);
    wait_idle();
    check("post_rst_latency", last_ok_cyc - acc, 3);

    // Back-to-back inst reads, rvalid 5 cycles late
    r_dly = 5;
    issue(0, 0, 2'd2, 32'h0000_0100, 0, 32'h1111_1111, acc);
    @(negedge clk);
    check("b2b_arid", arid, 0);
    issue(0, 0, 2'd2, 32'h0000_0104, 0, 32'h2222_2222, acc2);
    issue(0, 0, 2'd2, 32'h0000_0108, 0, 32'h3333_3333, acc3);
    wait_idle();
    check("b2b_spacing1", acc2 - acc, 9);
    check("b2b_spacing2", acc3 - acc2, 9);
    r_dly = 0;

    repeat (3) @(posedge clk);
    check("queue_empty", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
